combination_seq_lock_param: RTL and testbench
=============================================

// Module: combination_seq_lock_param
// PURPOSE
//  Parametrised serial combination lock: one code bit is entered per valid strobe, MSB first.
//  The expected code is compared bit by bit.
//  - Full match asserts UNLK.
//  - Each wrong bit counts a failed attempt; MAX_FAIL consecutive failures force a timed lockout.
//  - Per-bit HINT as in the single-code lock.
//  Sits between a debounced switch/button input stage and door/LED drivers.
// PARAMETERS
//  CODE_LEN    6          code length in bits, >=2
//  CODE        6'b101101  fixed unlock code, MSB entered first
//  MAX_FAIL    3          consecutive failed attempts before lockout, >=1
//  LOCKOUT_CYC 16         lockout duration in CLK cycles, >=2
// PORTS
//  CLK        in   1         clock, all state changes on posedge
//  CLR        in   1         synchronous active-high reset
//  X          in   1         code bit being entered
//  X_VLD      in   1         X sampled at posedge only when 1
//  UNLK       out  1         lock open (registered)
//  HINT       out  1         X matches expected bit at current position (combinational)
//  FAIL       out  1         one-cycle pulse on a failed attempt (registered)
//  LOCKOUT    out  1         lockout active, input ignored (registered)
//  POS        out  $clog2(CODE_LEN)  index of next expected bit (registered)
// BEHAVIOUR
//  - Reset (CLR=1 at posedge): state=ENTRY, POS=0, fail_cnt=0, lock_cnt=0;
//    UNLK=0, FAIL=0, LOCKOUT=0. CLR overrides every other event, including mid-lockout.
//  - exp_bit = code[CODE_LEN-1-POS].
//  - HINT = ~(X ^ exp_bit) in ENTRY, else 0. HINT does not depend on X_VLD.
//  - States:
//    * ENTRY, X_VLD=1, X==exp_bit, POS<CODE_LEN-1: POS++.
//    * ENTRY, X_VLD=1, X==exp_bit, POS==CODE_LEN-1: ->OPEN, UNLK=1 from next cycle, POS=0, fail_cnt=0.
//    * ENTRY, X_VLD=1, X!=exp_bit: FAIL pulses 1 cycle, POS=0, fail_cnt++.
//      If fail_cnt+1==MAX_FAIL: ->LOCKOUT, LOCKOUT=1 in the same cycle as the FAIL pulse,
//      lock_cnt=LOCKOUT_CYC-1, fail_cnt=0.
//      A wrong bit restarts the code; the wrong bit itself is not re-evaluated as bit 0.
//    * OPEN: UNLK=1. Any X_VLD=1 relocks: ->ENTRY, UNLK=0 next cycle. That input bit is consumed, not evaluated.
//    * LOCKOUT: X/X_VLD ignored. lock_cnt decrements each cycle. At lock_cnt==0: ->ENTRY, LOCKOUT=0 next cycle.
//      Total LOCKOUT high time = LOCKOUT_CYC cycles.
//  - X_VLD=0: hold all state. FAIL=0.
//  - Latency: decision bit sampled at edge k; UNLK/FAIL/LOCKOUT valid after edge k.
//  - Widths:
//    * POS saturates at CODE_LEN-1, never wraps past it.
//    * fail_cnt width $clog2(MAX_FAIL+1); lock_cnt width $clog2(LOCKOUT_CYC).
//  - Only one state is active at a time; UNLK and LOCKOUT are never both 1.
// CONFIGURATION
//  COMBO_LOCK_PROG_EN defined:
//   - Adds ports PROG (in, 1) and PROG_CODE (in, CODE_LEN).
//   - PROG=1 at posedge while in OPEN: loads PROG_CODE into the code register, ->ENTRY, UNLK=0.
//     PROG has priority over X_VLD.
//   - PROG outside OPEN is ignored.
//   - CLR reloads the code register with CODE.
//  COMBO_LOCK_PROG_EN undefined:
//   - No PROG ports; the code is the constant CODE.
// TESTING
//  (defaults: CODE=101101, MAX_FAIL=3, LOCKOUT_CYC=16)
//  1. CLR, then bits 1,0,1,1,0,1 with X_VLD=1 -> POS 1..5, UNLK=1 after 6th edge; HINT=1 on every bit.
//  2. Bits 1,0,0 -> FAIL pulse on 3rd edge, POS=0, UNLK stays 0; HINT=0 while X=0 at POS=2.
//  3. Three single wrong bits (0,0,0) -> 3 FAIL pulses; LOCKOUT=1 with 3rd FAIL for exactly 16 cycles.
//     Correct code entered during lockout is ignored; correct code afterwards -> UNLK=1.
//  4. 2 fails, then correct code -> UNLK=1, fail_cnt cleared; relock, 2 more fails -> no lockout.
//  5. CLR at cycle 5 of lockout and at POS=4 -> all outputs 0, POS=0 next cycle.
//     X_VLD=0 gaps mid-code -> state held.
//  6. PROG_EN build: unlock, PROG=1 with PROG_CODE=010011 -> relocked;
//     old code now fails; 010011 unlocks; CLR restores 101101.

Source files
------------

// File: rtl/combination_seq_lock_param.sv
// Serial combination lock: one code bit per X_VLD strobe, MSB first, with fail counting and timed lockout.
// Optional feature macro COMBO_LOCK_PROG_EN adds PROG/PROG_CODE to reprogram the code while open.
module combination_seq_lock_param #(
    parameter int                  CODE_LEN    = 6,
    parameter logic [CODE_LEN-1:0] CODE        = 6'b101101,
    parameter int                  MAX_FAIL    = 3,
    parameter int                  LOCKOUT_CYC = 16
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         X,
    input  logic                         X_VLD,
`ifdef COMBO_LOCK_PROG_EN
    input  logic                         PROG,
    input  logic [CODE_LEN-1:0]          PROG_CODE,
`endif
    output logic                         UNLK,
    output logic                         HINT,
    output logic                         FAIL,
    output logic                         LOCKOUT,
    output logic [$clog2(CODE_LEN)-1:0]  POS
);
    localparam int POS_W = $clog2(CODE_LEN);
    localparam int FC_W  = $clog2(MAX_FAIL + 1);
    localparam int LC_W  = $clog2(LOCKOUT_CYC);

    localparam logic [1:0] ST_ENTRY = 2'd0;
    localparam logic [1:0] ST_OPEN  = 2'd1;
    localparam logic [1:0] ST_LOCK  = 2'd2;

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAIL);
    localparam logic [LC_W-1:0]  LC_LOAD  = LC_W'(LOCKOUT_CYC - 1);

    logic [1:0]          state_r,   state_s;
    logic [POS_W-1:0]    pos_r,     pos_s;
    logic [FC_W-1:0]     fc_r,      fc_s;
    logic [LC_W-1:0]     lc_r,      lc_s;
    logic                unlk_r,    unlk_s;
    logic                fail_r,    fail_s;
    logic                lockout_r, lockout_s;
    logic                hint_s;
    logic [CODE_LEN-1:0] code_s;
    logic [CODE_LEN-1:0] code_shift_s;
    logic                exp_bit_s;

`ifdef COMBO_LOCK_PROG_EN
    logic [CODE_LEN-1:0] code_r, code_nxt_s;
    assign code_s = code_r;
`else
    assign code_s = CODE;
`endif

    // Shifting the code left by POS brings the expected bit to the MSB.
    assign code_shift_s = code_s << pos_r;
    assign exp_bit_s    = code_shift_s[CODE_LEN-1];

    // Hint compares the live input with the expected bit, only while entering.
    always_comb begin
        hint_s = 1'b0;
        if (state_r == ST_ENTRY) begin
            hint_s = ~(X ^ exp_bit_s);
        end else begin
            hint_s = 1'b0;
        end
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s   = state_r;
        pos_s     = pos_r;
        fc_s      = fc_r;
        lc_s      = lc_r;
        unlk_s    = unlk_r;
        lockout_s = lockout_r;
        fail_s    = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
        code_nxt_s = code_r;
`endif
        case (state_r)
            ST_ENTRY: begin
                if (X_VLD) begin
                    if (X == exp_bit_s) begin
                        if (pos_r == POS_LAST) begin
                            state_s = ST_OPEN;
                            unlk_s  = 1'b1;
                            pos_s   = {POS_W{1'b0}};
                            fc_s    = {FC_W{1'b0}};
                        end else begin
                            pos_s = pos_r + POS_W'(1);
                        end
                    end else begin
                        fail_s = 1'b1;
                        pos_s  = {POS_W{1'b0}};
                        if ((fc_r + FC_W'(1)) == FC_MAX) begin
                            state_s   = ST_LOCK;
                            lockout_s = 1'b1;
                            lc_s      = LC_LOAD;
                            fc_s      = {FC_W{1'b0}};
                        end else begin
                            fc_s = fc_r + FC_W'(1);
                        end
                    end
                end else begin
                    state_s = ST_ENTRY;
                end
            end
            ST_OPEN: begin
`ifdef COMBO_LOCK_PROG_EN
                if (PROG) begin
                    code_nxt_s = PROG_CODE;
                    state_s    = ST_ENTRY;
                    unlk_s     = 1'b0;
                end else if (X_VLD) begin
                    state_s = ST_ENTRY;
                    unlk_s  = 1'b0;
                end else begin
                    state_s = ST_OPEN;
                end
`else
                if (X_VLD) begin
                    state_s = ST_ENTRY;
                    unlk_s  = 1'b0;
                end else begin
                    state_s = ST_OPEN;
                end
`endif
            end
            ST_LOCK: begin
                if (lc_r == {LC_W{1'b0}}) begin
                    state_s   = ST_ENTRY;
                    lockout_s = 1'b0;
                end else begin
                    lc_s = lc_r - LC_W'(1);
                end
            end
            default: begin
                state_s   = ST_ENTRY;
                pos_s     = {POS_W{1'b0}};
                fc_s      = {FC_W{1'b0}};
                lc_s      = {LC_W{1'b0}};
                unlk_s    = 1'b0;
                lockout_s = 1'b0;
            end
        endcase
    end

    // State and output registers; CLR wins over every other event.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r   <= ST_ENTRY;
            pos_r     <= {POS_W{1'b0}};
            fc_r      <= {FC_W{1'b0}};
            lc_r      <= {LC_W{1'b0}};
            unlk_r    <= 1'b0;
            fail_r    <= 1'b0;
            lockout_r <= 1'b0;
`ifdef COMBO_LOCK_PROG_EN
            code_r    <= CODE;
`endif
        end else begin
            state_r   <= state_s;
            pos_r     <= pos_s;
            fc_r      <= fc_s;
            lc_r      <= lc_s;
            unlk_r    <= unlk_s;
            fail_r    <= fail_s;
            lockout_r <= lockout_s;
`ifdef COMBO_LOCK_PROG_EN
            code_r    <= code_nxt_s;
`endif
        end
    end

    assign UNLK    = unlk_r;
    assign FAIL    = fail_r;
    assign LOCKOUT = lockout_r;
    assign POS     = pos_r;
    assign HINT    = hint_s;

endmodule

// File: tb/tb_combination_seq_lock_param.sv
// Bench for combination_seq_lock_param: directed scenarios plus random traffic against a behavioural model.
module tb_combination_seq_lock_param;
    localparam int         CODE_LEN    = 6;
    localparam logic [5:0] CODE        = 6'b101101;
    localparam int         MAX_FAIL    = 3;
    localparam int         LOCKOUT_CYC = 16;

    logic       CLK = 1'b0;
    logic       CLR, X, X_VLD;
    logic       UNLK, hint_w, FAIL, LOCKOUT;
    logic [2:0] POS;
`ifdef COMBO_LOCK_PROG_EN
    logic       PROG;
    logic [5:0] PROG_CODE;
`endif

    combination_seq_lock_param #(
        .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
    ) dut (
        .CLK(CLK), .CLR(CLR), .X(X), .X_VLD(X_VLD),
`ifdef COMBO_LOCK_PROG_EN
        .PROG(PROG), .PROG_CODE(PROG_CODE),
`endif
        .UNLK(UNLK), .HINT(hint_w), .FAIL(FAIL), .LOCKOUT(LOCKOUT), .POS(POS)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: plain counters describing what the lock should be doing.
    bit         m_open, m_lockout, m_failp;
    int         m_pos, m_fails, m_lock_left;
    logic [5:0] m_code;

    function automatic bit m_exp();
        return m_code[CODE_LEN-1-m_pos];
    endfunction

    task automatic model_reset();
        m_open = 0; m_lockout = 0; m_failp = 0;
        m_pos = 0; m_fails = 0; m_lock_left = 0;
        m_code = CODE;
    endtask

    task automatic model_step(input bit clr, input bit vld, input bit x, input bit prog, input logic [5:0] pcode);
        if (clr) begin
            model_reset();
        end else if (m_lockout) begin
            m_failp = 0;
            m_lock_left--;
            if (m_lock_left == 0) m_lockout = 0;
        end else if (m_open) begin
            m_failp = 0;
            if (prog) begin
                m_code = pcode;
                m_open = 0;
            end else if (vld) begin
                m_open = 0;
            end
        end else begin
            m_failp = 0;
            if (vld) begin
                if (x == m_exp()) begin
                    if (m_pos == CODE_LEN - 1) begin
                        m_open = 1; m_pos = 0; m_fails = 0;
                    end else begin
                        m_pos++;
                    end
                end else begin
                    m_failp = 1; m_pos = 0; m_fails++;
                    if (m_fails == MAX_FAIL) begin
                        m_lockout = 1; m_lock_left = LOCKOUT_CYC; m_fails = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive on the falling edge, check the hint output, then check registered outputs after posedge.
    task automatic cyc(input bit clr, input bit vld, input bit x, input bit prog = 1'b0, input logic [5:0] pcode = 6'd0);
        bit p;
`ifdef COMBO_LOCK_PROG_EN
        p = prog;
`else
        p = 1'b0;
`endif
        @(negedge CLK);
        CLR = clr; X_VLD = vld; X = x;
`ifdef COMBO_LOCK_PROG_EN
        PROG = p; PROG_CODE = pcode;
`endif
        #1;
        chk("hint", {31'd0, hint_w}, (!m_open && !m_lockout) ? {31'd0, x == m_exp()} : 32'd0);
        @(posedge CLK);
        model_step(clr, vld, x, p, pcode);
        #1;
        chk("unlk",    {31'd0, UNLK},    {31'd0, m_open});
        chk("fail",    {31'd0, FAIL},    {31'd0, m_failp});
        chk("lockout", {31'd0, LOCKOUT}, {31'd0, m_lockout});
        chk("pos",     {29'd0, POS},     m_pos);
        chk("excl",    {31'd0, UNLK & LOCKOUT}, 32'd0);
    endtask

    task automatic enter(input logic [5:0] c);
        for (int i = CODE_LEN - 1; i >= 0; i--) cyc(1'b0, 1'b1, c[i]);
    endtask

    initial begin
        int n;
        int ri;
        bit rx, rv, rc, rp;
        CLR = 1'b1; X = 1'b0; X_VLD = 1'b0;
`ifdef COMBO_LOCK_PROG_EN
        PROG = 1'b0; PROG_CODE = 6'd0;
`endif
        model_reset();

        // Reset state
        cyc(1'b1, 1'b0, 1'b0);
        chk("rst_pos", {29'd0, POS}, 32'd0);
        chk("rst_unlk", {31'd0, UNLK}, 32'd0);

        // Correct code unlocks; any strobe relocks
        enter(CODE);
        chk("t1_unlk", {31'd0, UNLK}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_relock", {31'd0, UNLK}, 32'd0);

        // Wrong third bit
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2_fail", {31'd0, FAIL}, 32'd1);
        chk("t2_pos", {29'd0, POS}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0);

        // Three failures -> lockout for exactly LOCKOUT_CYC cycles, input ignored
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        chk("t3_lockout", {31'd0, LOCKOUT}, 32'd1);
        chk("t3_failp", {31'd0, FAIL}, 32'd1);
        n = 1;
        ri = 0;
        while (ri < 40) begin
            cyc(1'b0, 1'b1, CODE[CODE_LEN-1-(ri % CODE_LEN)]);
            ri++;
            if (LOCKOUT) n++;
            else break;
        end
        chk("t3_len", n, LOCKOUT_CYC);
        chk("t3_unlk", {31'd0, UNLK}, 32'd0);
        enter(CODE);
        chk("t3_unlk_after", {31'd0, UNLK}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1);

        // Success clears the fail count
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        enter(CODE);
        chk("t4_unlk", {31'd0, UNLK}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        chk("t4_nolock", {31'd0, LOCKOUT}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0);

        // CLR mid-lockout, then gaps mid-code and CLR at POS=4
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("t5_clr_lock", {31'd0, LOCKOUT}, 32'd0);
        for (int i = CODE_LEN - 1; i >= 2; i--) begin
            cyc(1'b0, 1'b1, CODE[i]);
            cyc(1'b0, 1'b0, ~CODE[i]);
        end
        chk("t5_pos4", {29'd0, POS}, 32'd4);
        cyc(1'b1, 1'b1, CODE[1]);
        chk("t5_clr_pos", {29'd0, POS}, 32'd0);

`ifdef COMBO_LOCK_PROG_EN
        // Reprogram while open
        enter(CODE);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 6'b010011);
        chk("t6_relock", {31'd0, UNLK}, 32'd0);
        enter(CODE);
        chk("t6_old", {31'd0, UNLK}, 32'd0);
        enter(6'b010011);
        chk("t6_new", {31'd0, UNLK}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        enter(CODE);
        chk("t6_restore", {31'd0, UNLK}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
`endif

        // Random traffic biased toward correct bits so unlocks and lockouts both occur
        for (int k = 0; k < 600; k++) begin
            rc = ($urandom_range(0, 199) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rp = ($urandom_range(0, 7) == 0);
            if (!m_open && !m_lockout && $urandom_range(0, 9) < 8) rx = m_exp();
            else rx = $urandom_range(0, 1);
            cyc(rc, rv, rx, rp, 6'($urandom_range(0, 63)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
